// File: rtl/noise_channel_v2.sv
// -----------------------------------------------------------------------------
// noise_channel_v2
// APU noise voice. An LFSR noise source, a length counter and a volume
// envelope share one clock domain and are advanced by single-cycle
// frame-sequencer strobes. The registered sample feeds the mixer.
//
// Ports
//   clk        system clock
//   rst        synchronous reset, active-high
//   tick256    one-cycle strobe, length clock
//   tick64     one-cycle strobe, envelope clock
//   lenLoad    length load L; a new note plays for 2^LEN_W - L length ticks
//   startVol   initial volume
//   envAdd     envelope direction (1 = up, 0 = down)
//   envPeriod  envelope period in tick64 strobes, 0 = envelope frozen
//   clkShift   frequency shift s applied to the base period
//   widthMode  narrow (short-period) LFSR mode
//   divisor    divisor code r selecting the base period
//   trigger    one-cycle note start
//   lenEnable  length counter enable
//   noise      registered output sample
//   active     channel enabled flag
// -----------------------------------------------------------------------------
module noise_channel_v2 #(
  parameter int LFSR_W     = 15,
  parameter int NARROW_TAP = 6,
  parameter int VOL_W      = 4,
  parameter int LEN_W      = 6,
  parameter int SHIFT_STOP = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick256,
  input  logic             tick64,
  input  logic [LEN_W-1:0] lenLoad,
  input  logic [VOL_W-1:0] startVol,
  input  logic             envAdd,
  input  logic [2:0]       envPeriod,
  input  logic [3:0]       clkShift,
  input  logic             widthMode,
  input  logic [2:0]       divisor,
  input  logic             trigger,
  input  logic             lenEnable,
  output logic [VOL_W-1:0] noise,
  output logic             active
);

  // Largest period is 112 << 15, which needs 7 + 15 bits.
  localparam int TMR_W = 22;
  // Length count holds up to 2^LEN_W, one bit wider than the load value.
  localparam int CNT_W = LEN_W + 1;

  localparam logic [TMR_W-1:0]  TMR_ONE   = {{(TMR_W-1){1'b0}}, 1'b1};
  localparam logic [TMR_W-1:0]  TMR_ZERO  = {TMR_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{LEN_W{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_FULL  = {1'b1, {LEN_W{1'b0}}};
  localparam logic [VOL_W-1:0]  VOL_ZERO  = {VOL_W{1'b0}};
  localparam logic [VOL_W-1:0]  VOL_ONE   = {{(VOL_W-1){1'b0}}, 1'b1};
  localparam logic [VOL_W-1:0]  VOL_MAX   = {VOL_W{1'b1}};
  localparam logic [LFSR_W-1:0] LFSR_SEED = {LFSR_W{1'b1}};
  localparam logic [4:0]        SHIFT_LIM = 5'(SHIFT_STOP);

  // One LFSR step; in narrow mode the feedback is also written into the
  // tap so the low bits form a short independent loop.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] sr,
                                                  input logic narrow);
    logic              fb;
    logic [LFSR_W-1:0] nx;
    fb = sr[0] ^ sr[1];
    nx = {fb, sr[LFSR_W-1:1]};
    if (narrow) begin
      nx[NARROW_TAP] = fb;
    end else begin
      nx = nx;
    end
    return nx;
  endfunction

  // One envelope step with saturation at both ends.
  function automatic logic [VOL_W-1:0] vol_step(input logic [VOL_W-1:0] v,
                                                input logic up);
    logic [VOL_W-1:0] r;
    if (up) begin
      r = (v == VOL_MAX) ? v : v + VOL_ONE;
    end else begin
      r = (v == VOL_ZERO) ? v : v - VOL_ONE;
    end
    return r;
  endfunction

  logic [LFSR_W-1:0] sr_r, sr_s;
  logic [TMR_W-1:0]  tmr_r, tmr_s;
  logic [CNT_W-1:0]  len_r, len_s;
  logic [VOL_W-1:0]  vol_r, vol_s;
  logic [2:0]        env_r, env_s;
  logic              active_s;
  logic [VOL_W-1:0]  noise_s;
  logic [TMR_W-1:0]  base_s;
  logic [TMR_W-1:0]  period_s;
  logic              step_en_s;
  logic              dac_off_s;
  logic              len_tick_s;

  // Full timer period: base 8 for r = 0, else 16*r, scaled by 2^s.
  always_comb begin
    if (divisor == 3'd0) begin
      base_s = {{(TMR_W-4){1'b0}}, 4'd8};
    end else begin
      base_s = {{(TMR_W-7){1'b0}}, divisor, 4'd0};
    end
    period_s  = base_s << clkShift;
    step_en_s = ({1'b0, clkShift} < SHIFT_LIM);
    dac_off_s = (startVol == VOL_ZERO) && !envAdd;
    len_tick_s = tick256 && lenEnable && (len_r != CNT_ZERO);
  end

  // Next-state logic; a trigger overrides every same-cycle tick or step.
  always_comb begin
    sr_s     = sr_r;
    tmr_s    = tmr_r;
    len_s    = len_r;
    vol_s    = vol_r;
    env_s    = env_r;
    active_s = active;
    noise_s  = (active && !sr_r[0]) ? vol_r : VOL_ZERO;

    if (trigger) begin
      sr_s     = LFSR_SEED;
      tmr_s    = period_s;
      vol_s    = startVol;
      env_s    = envPeriod;
      active_s = !dac_off_s;
      if (len_r == CNT_ZERO) begin
        len_s = CNT_FULL - {1'b0, lenLoad};
      end else begin
        len_s = len_r;
      end
    end else begin
      // Timer at 1 (or 0 straight after reset) reloads and requests a step.
      if (tmr_r <= TMR_ONE) begin
        tmr_s = period_s;
        if (step_en_s) begin
          sr_s = lfsr_step(sr_r, widthMode);
        end else begin
          sr_s = sr_r;
        end
      end else begin
        tmr_s = tmr_r - TMR_ONE;
        sr_s  = sr_r;
      end

      if (len_tick_s) begin
        len_s = len_r - CNT_ONE;
      end else begin
        len_s = len_r;
      end

      // Envelope timer at 1 (or 0) means this tick completes a period.
      if (tick64 && (envPeriod != 3'd0)) begin
        if (env_r <= 3'd1) begin
          env_s = envPeriod;
          vol_s = vol_step(vol_r, envAdd);
        end else begin
          env_s = env_r - 3'd1;
          vol_s = vol_r;
        end
      end else begin
        env_s = env_r;
        vol_s = vol_r;
      end

      if (dac_off_s) begin
        active_s = 1'b0;
      end else if (len_tick_s && (len_r == CNT_ONE)) begin
        active_s = 1'b0;
      end else begin
        active_s = active;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_r   <= LFSR_SEED;
      tmr_r  <= TMR_ZERO;
      len_r  <= CNT_ZERO;
      vol_r  <= VOL_ZERO;
      env_r  <= 3'd0;
      active <= 1'b0;
      noise  <= VOL_ZERO;
    end else begin
      sr_r   <= sr_s;
      tmr_r  <= tmr_s;
      len_r  <= len_s;
      vol_r  <= vol_s;
      env_r  <= env_s;
      active <= active_s;
      noise  <= noise_s;
    end
  end

endmodule

// File: tb/tb_noise_channel_v2.sv
// -----------------------------------------------------------------------------
// tb_noise_channel_v2
// Directed bench for noise_channel_v2 with default parameters. Inputs change
// on the falling edge and outputs are sampled on the falling edge, so every
// sample sees the state left by the preceding rising edge.
// -----------------------------------------------------------------------------
module tb_noise_channel_v2;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick256;
  logic       tick64;
  logic [5:0] lenLoad;
  logic [3:0] startVol;
  logic       envAdd;
  logic [2:0] envPeriod;
  logic [3:0] clkShift;
  logic       widthMode;
  logic [2:0] divisor;
  logic       trigger;
  logic       lenEnable;
  logic [3:0] noise;
  logic       active;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  noise_channel_v2 dut (
    .clk(clk), .rst(rst), .tick256(tick256), .tick64(tick64),
    .lenLoad(lenLoad), .startVol(startVol), .envAdd(envAdd),
    .envPeriod(envPeriod), .clkShift(clkShift), .widthMode(widthMode),
    .divisor(divisor), .trigger(trigger), .lenEnable(lenEnable),
    .noise(noise), .active(active)
  );

  // Reference 15-bit LFSR step, narrow tap at bit 6.
  function automatic logic [14:0] ref_step(input logic [14:0] s, input logic narrow);
    logic        fb;
    logic [14:0] r;
    fb = s[0] ^ s[1];
    r  = {fb, s[14:1]};
    if (narrow) r[6] = fb;
    return r;
  endfunction

  function automatic logic [3:0] ref_noise(input logic [14:0] s, input logic [3:0] v);
    return s[0] ? 4'd0 : v;
  endfunction

  task automatic apply_rst();
    tick256 = 1'b0; tick64 = 1'b0; lenLoad = 6'd0; startVol = 4'd0;
    envAdd = 1'b0; envPeriod = 3'd0; clkShift = 4'd0; widthMode = 1'b0;
    divisor = 3'd0; trigger = 1'b0; lenEnable = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_trigger();
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
  endtask

  task automatic pulse_tick256();
    tick256 = 1'b1;
    @(negedge clk);
    tick256 = 1'b0;
  endtask

  task automatic pulse_tick64();
    tick64 = 1'b1;
    @(negedge clk);
    tick64 = 1'b0;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; trigger = 1'b1;
    tick256 = 1'b0; tick64 = 1'b0; lenLoad = 6'd0; startVol = 4'd15;
    envAdd = 1'b0; envPeriod = 3'd0; clkShift = 4'd0; widthMode = 1'b0;
    divisor = 3'd0; lenEnable = 1'b0;
    wait_clk(3);
    trigger = 1'b0;
    checks++;
    if (noise !== 4'd0) begin errors++; $display("FAIL reset_noise got %0d expected 0", noise); end
    checks++;
    if (active !== 1'b0) begin errors++; $display("FAIL reset_active got %0b expected 0", active); end
    rst = 1'b0;
  endtask

  task automatic test_lfsr_wide();
    logic [14:0] m;
    apply_rst();
    startVol = 4'd15;
    pulse_trigger();
    m = 15'h7FFF;
    wait_clk(4);
    checks++;
    if (active !== 1'b1) begin errors++; $display("FAIL wide_active got %0b expected 1", active); end
    for (int k = 0; k < 32; k++) begin
      checks++;
      if (noise !== ref_noise(m, 4'd15)) begin
        errors++; $display("FAIL wide_step%0d got %0d expected %0d", k, noise, ref_noise(m, 4'd15));
      end
      m = ref_step(m, 1'b0);
      wait_clk(8);
    end
  endtask

  task automatic test_lfsr_narrow();
    logic [14:0] m;
    apply_rst();
    startVol = 4'd15; widthMode = 1'b1;
    pulse_trigger();
    m = 15'h7FFF;
    wait_clk(4);
    for (int k = 0; k < 140; k++) begin
      checks++;
      if (noise !== ref_noise(m, 4'd15)) begin
        errors++; $display("FAIL narrow_step%0d got %0d expected %0d", k, noise, ref_noise(m, 4'd15));
      end
      m = ref_step(m, 1'b1);
      wait_clk(8);
    end
    // Back to wide mode without a reload.
    widthMode = 1'b0;
    for (int k = 0; k < 30; k++) begin
      checks++;
      if (noise !== ref_noise(m, 4'd15)) begin
        errors++; $display("FAIL rewide_step%0d got %0d expected %0d", k, noise, ref_noise(m, 4'd15));
      end
      m = ref_step(m, 1'b0);
      wait_clk(8);
    end
  endtask

  task automatic test_slow_and_freeze();
    logic [14:0] m;
    apply_rst();
    startVol = 4'd15; divisor = 3'd2; clkShift = 4'd3;
    pulse_trigger();
    // Period 256: the 15th step lands on edge 3840 and shows on noise at 3841.
    wait_clk(3840);
    checks++;
    if (noise !== 4'd0) begin errors++; $display("FAIL slow_edge3840 got %0d expected 0", noise); end
    wait_clk(1);
    checks++;
    if (noise !== 4'd15) begin errors++; $display("FAIL slow_edge3841 got %0d expected 15", noise); end
    m = 15'h7FFF;
    for (int k = 0; k < 15; k++) m = ref_step(m, 1'b0);
    wait_clk(127);
    for (int k = 15; k < 20; k++) begin
      checks++;
      if (noise !== ref_noise(m, 4'd15)) begin
        errors++; $display("FAIL slow_step%0d got %0d expected %0d", k, noise, ref_noise(m, 4'd15));
      end
      m = ref_step(m, 1'b0);
      wait_clk(256);
    end
    clkShift = 4'd14;
    for (int i = 0; i < 10; i++) begin
      wait_clk(1000);
      checks++;
      if (noise !== ref_noise(m, 4'd15)) begin
        errors++; $display("FAIL frozen_%0d got %0d expected %0d", i, noise, ref_noise(m, 4'd15));
      end
    end
  endtask

  task automatic test_length();
    apply_rst();
    startVol = 4'd15; lenLoad = 6'd60; lenEnable = 1'b1;
    pulse_trigger();
    wait_clk(124);
    clkShift = 4'd14;
    checks++;
    if (noise !== 4'd15) begin errors++; $display("FAIL len_pre_noise got %0d expected 15", noise); end
    for (int i = 1; i <= 4; i++) begin
      pulse_tick256();
      checks++;
      if (active !== (i < 4)) begin
        errors++; $display("FAIL len_tick%0d active got %0b expected %0b", i, active, (i < 4));
      end
    end
    checks++;
    if (noise !== 4'd15) begin errors++; $display("FAIL len_noise_lag got %0d expected 15", noise); end
    wait_clk(1);
    checks++;
    if (noise !== 4'd0) begin errors++; $display("FAIL len_noise_off got %0d expected 0", noise); end
    // Retrigger from zero reloads 64 - 60 = 4.
    pulse_trigger();
    checks++;
    if (active !== 1'b1) begin errors++; $display("FAIL retrig_active got %0b expected 1", active); end
    pulse_tick256();
    pulse_tick256();
    // Retrigger with a nonzero count leaves the remaining 2 in place.
    pulse_trigger();
    pulse_tick256();
    checks++;
    if (active !== 1'b1) begin errors++; $display("FAIL retrig_keep got %0b expected 1", active); end
    pulse_tick256();
    checks++;
    if (active !== 1'b0) begin errors++; $display("FAIL retrig_expire got %0b expected 0", active); end
    // With lenEnable low the count does not move.
    lenEnable = 1'b0;
    pulse_trigger();
    repeat (5) pulse_tick256();
    checks++;
    if (active !== 1'b1) begin errors++; $display("FAIL len_disabled got %0b expected 1", active); end
  endtask

  task automatic test_envelope();
    logic [3:0] exp_v [4];
    logic [2:0] per_v [4];
    exp_v[0] = 4'd1; exp_v[1] = 4'd1; exp_v[2] = 4'd0; exp_v[3] = 4'd0;
    per_v[0] = 3'd1; per_v[1] = 3'd0; per_v[2] = 3'd1; per_v[3] = 3'd1;
    apply_rst();
    startVol = 4'd2; envAdd = 1'b0; envPeriod = 3'd1;
    pulse_trigger();
    wait_clk(124);
    clkShift = 4'd14;
    checks++;
    if (noise !== 4'd2) begin errors++; $display("FAIL env_start got %0d expected 2", noise); end
    for (int i = 0; i < 4; i++) begin
      envPeriod = per_v[i];
      pulse_tick64();
      wait_clk(1);
      checks++;
      if (noise !== exp_v[i]) begin
        errors++; $display("FAIL env_down%0d got %0d expected %0d", i, noise, exp_v[i]);
      end
    end
    // DAC off forces active low, also through a trigger.
    startVol = 4'd0; envAdd = 1'b0;
    wait_clk(1);
    checks++;
    if (active !== 1'b0) begin errors++; $display("FAIL dac_off got %0b expected 0", active); end
    pulse_trigger();
    checks++;
    if (active !== 1'b0) begin errors++; $display("FAIL dac_off_trig got %0b expected 0", active); end
    // Upward envelope saturates at 15.
    startVol = 4'd14; envAdd = 1'b1; envPeriod = 3'd1; clkShift = 4'd0;
    pulse_trigger();
    wait_clk(124);
    clkShift = 4'd14;
    checks++;
    if (noise !== 4'd14) begin errors++; $display("FAIL env_up_start got %0d expected 14", noise); end
    for (int i = 0; i < 2; i++) begin
      pulse_tick64();
      wait_clk(1);
      checks++;
      if (noise !== 4'd15) begin errors++; $display("FAIL env_up%0d got %0d expected 15", i, noise); end
    end
  endtask

  task automatic test_collision();
    logic [14:0] m;
    apply_rst();
    startVol = 4'd15; lenLoad = 6'd60; lenEnable = 1'b1;
    pulse_trigger();
    wait_clk(7);
    // Edge 8 would step the LFSR; the trigger and a tick256 share it.
    trigger = 1'b1; tick256 = 1'b1;
    @(negedge clk);
    trigger = 1'b0; tick256 = 1'b0;
    m = 15'h7FFF;
    wait_clk(4);
    for (int k = 0; k < 17; k++) begin
      checks++;
      if (noise !== ref_noise(m, 4'd15)) begin
        errors++; $display("FAIL coll_step%0d got %0d expected %0d", k, noise, ref_noise(m, 4'd15));
      end
      m = ref_step(m, 1'b0);
      wait_clk(8);
    end
    // Reset mid-note, together with a trigger, clears the outputs.
    rst = 1'b1; trigger = 1'b1;
    @(negedge clk);
    rst = 1'b0; trigger = 1'b0;
    checks++;
    if (noise !== 4'd0) begin errors++; $display("FAIL midrst_noise got %0d expected 0", noise); end
    checks++;
    if (active !== 1'b0) begin errors++; $display("FAIL midrst_active got %0b expected 0", active); end
    // The coincident tick is dropped, so four further ticks are needed.
    pulse_trigger();
    trigger = 1'b1; tick256 = 1'b1;
    @(negedge clk);
    trigger = 1'b0; tick256 = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      pulse_tick256();
      checks++;
      if (active !== (i < 4)) begin
        errors++; $display("FAIL coll_tick%0d active got %0b expected %0b", i, active, (i < 4));
      end
    end
  endtask

  initial begin
    test_reset();
    test_lfsr_wide();
    test_lfsr_narrow();
    test_slow_and_freeze();
    test_length();
    test_envelope();
    test_collision();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
